// File: rtl/seg7_frame_decoder_if.sv
// seg7_frame_decoder_if: digit-stream bus between a 7-segment scanner and the frame decoder
//   iSEG      segment pattern, active-low, bit0=a .. bit6=g
//   iDIG_SEL  one-hot digit index, bit0=HEX0 .. bit3=HEX3
//   iSTROBE   iSEG/iDIG_SEL valid this cycle
//   oVALUE    last completed 16-bit word
//   oVALID    one-cycle pulse when oVALUE updates
//   oFRAME_ERR  qualifies oVALID: some digit of the frame was unrecognised
//   oSEL_ERR  one-cycle pulse after a strobe with non-one-hot iDIG_SEL
//   oTIMEOUT  one-cycle pulse when a partial frame is discarded
//   oBUSY     a frame is partially collected
interface seg7_frame_decoder_if;
   logic [6:0]  iSEG;
   logic [3:0]  iDIG_SEL;
   logic        iSTROBE;
   logic [15:0] oVALUE;
   logic        oVALID;
   logic        oFRAME_ERR;
   logic        oSEL_ERR;
   logic        oTIMEOUT;
   logic        oBUSY;
   modport master (output iSEG, iDIG_SEL, iSTROBE,
                   input oVALUE, oVALID, oFRAME_ERR, oSEL_ERR, oTIMEOUT, oBUSY);
   modport slave  (input iSEG, iDIG_SEL, iSTROBE,
                   output oVALUE, oVALID, oFRAME_ERR, oSEL_ERR, oTIMEOUT, oBUSY);
endinterface

// File: rtl/seg7_frame_decoder.sv
// seg7_frame_decoder: decodes 7-segment digits back to nibbles and assembles HEX3..HEX0 into a 16-bit word
//   CLOCK_50  system clock, rising edge
//   RESETN    asynchronous active-low reset
//   bus       seg7_frame_decoder_if.slave: digit stream in, word/valid/error pulses out
module seg7_frame_decoder #(
   parameter int TIMEOUT = 1024,
   parameter int TW      = 11
) (
   input  logic                 CLOCK_50,
   input  logic                 RESETN,
   seg7_frame_decoder_if.slave  bus
);
   typedef enum logic {IDLE, COLLECT} state_t;
   localparam logic [TW-1:0] LIM = TW'(TIMEOUT == 0 ? 0 : TIMEOUT - 1);
   state_t        r_state, w_state_nx;
   logic [3:0]    r_seen, r_err, w_seen_nx, w_err_nx, w_nib;
   logic [15:0]   r_slots, w_slots_nx, r_value;
   logic [TW-1:0] r_timer;
   logic          r_valid, r_frame_err, r_sel_err, r_timeout;
   logic          w_ok, w_onehot, w_acc, w_done, w_expire;
   always_comb begin
      w_ok  = 1'b1;
      w_nib = 4'h0;
      case (bus.iSEG)
         7'b1000000: w_nib = 4'h0;
         7'b1111001: w_nib = 4'h1;
         7'b0100100: w_nib = 4'h2;
         7'b0110000: w_nib = 4'h3;
         7'b0011001: w_nib = 4'h4;
         7'b0010010: w_nib = 4'h5;
         7'b0000010: w_nib = 4'h6;
         7'b1111000: w_nib = 4'h7;
         7'b0000000: w_nib = 4'h8;
         7'b0011000: w_nib = 4'h9;
         7'b0001000: w_nib = 4'hA;
         7'b0000011: w_nib = 4'hB;
         7'b1000110: w_nib = 4'hC;
         7'b0100001: w_nib = 4'hD;
         7'b0000110: w_nib = 4'hE;
         7'b0001110: w_nib = 4'hF;
         default:    w_ok  = 1'b0;
      endcase
   end
   assign w_onehot  = (bus.iDIG_SEL != 4'd0) && ((bus.iDIG_SEL & (bus.iDIG_SEL - 4'd1)) == 4'd0);
   assign w_acc     = bus.iSTROBE && w_onehot;
   assign w_seen_nx = w_acc ? (r_seen | bus.iDIG_SEL) : r_seen;
   assign w_err_nx  = w_acc ? ((r_err & ~bus.iDIG_SEL) | (bus.iDIG_SEL & {4{~w_ok}})) : r_err;
   assign w_done    = w_acc && (w_seen_nx == 4'hF);
   // The timer holds cycles elapsed since the first strobe; completion on the expiry cycle wins.
   assign w_expire  = (r_state == COLLECT) && (TIMEOUT != 0) && (r_timer >= LIM) && !w_done;
   always_comb begin
      w_slots_nx = r_slots;
      for (int k = 0; k < 4; k++)
         if (w_acc && bus.iDIG_SEL[k]) w_slots_nx[4*k +: 4] = w_nib;
   end
   always_comb begin
      w_state_nx = r_state;
      if (w_done || w_expire) w_state_nx = IDLE;
      else if (w_acc)         w_state_nx = COLLECT;
   end
   always_ff @(posedge CLOCK_50 or negedge RESETN)
      if (!RESETN) r_state <= IDLE;
      else         r_state <= w_state_nx;
   always_ff @(posedge CLOCK_50 or negedge RESETN)
      if (!RESETN) begin
         r_seen      <= '0;
         r_err       <= '0;
         r_slots     <= '0;
         r_timer     <= '0;
         r_value     <= '0;
         r_valid     <= 1'b0;
         r_frame_err <= 1'b0;
         r_sel_err   <= 1'b0;
         r_timeout   <= 1'b0;
      end else begin
         r_valid     <= w_done;
         r_frame_err <= w_done && (w_err_nx != 4'd0);
         r_sel_err   <= bus.iSTROBE && !w_onehot;
         r_timeout   <= w_expire;
         r_slots     <= w_slots_nx;
         if (w_done) r_value <= w_slots_nx;
         r_seen      <= (w_done || w_expire) ? 4'd0 : w_seen_nx;
         r_err       <= (w_done || w_expire) ? 4'd0 : w_err_nx;
         // The strobe cycle itself counts as elapsed cycle 0, so the first register value is 1.
         r_timer     <= (w_done || w_expire) ? '0 :
                        (r_state == IDLE)    ? {{(TW-1){1'b0}}, w_acc} : r_timer + 1'b1;
      end
   assign bus.oVALUE     = r_value;
   assign bus.oVALID     = r_valid;
   assign bus.oFRAME_ERR = r_frame_err;
   assign bus.oSEL_ERR   = r_sel_err;
   assign bus.oTIMEOUT   = r_timeout;
   assign bus.oBUSY      = r_seen != 4'd0;
endmodule
